dm_arbiter: RTL

//   Two-port arbiter and sequencer in front of the single-port 4 KiB word data memory.

---
 rtl/dm_arbiter_if.sv | 47 ++++
 rtl/dm_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter_if.sv
// Bundle between the two memory requesters, the arbiter and the word-only data memory.
// master = requester/memory side, slave = arbiter side.
interface dm_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [BE_W-1:0]   be0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [BE_W-1:0]   be1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;

    logic [DATA_W-1:0] rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output req0, we0, addr0, be0, wdata0,
        output req1, we1, addr1, be1, wdata1,
        output mem_dout,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata,
        input  mem_addr, mem_din, mem_wr
    );

    modport slave (
        input  req0, we0, addr0, be0, wdata0,
        input  req1, we1, addr1, be1, wdata1,
        input  mem_dout,
        output gnt0, rvalid0, gnt1, rvalid1, rdata,
        output mem_addr, mem_din, mem_wr
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the word-only data memory; byte-enable stores use read-modify-write.
// Define DM_ARB_RR_EN for round-robin tie-break; otherwise port 0 has fixed priority.
//
// state  | meaning
// S_IDLE | waiting; samples requests, grants one, latches its fields
// S_RD   | memory read of latched address (load data or RMW old word)
// S_WR   | memory write of latched address (mem_wr high)
module dm_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    dm_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              port_q, port_d;

    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              mem_wr_q, mem_wr_d;

    logic              any_req;
    logic              win1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;

    assign any_req = bus.req0 | bus.req1;

`ifdef DM_ARB_RR_EN
    // last_q = port granted most recently; reset value 1 gives port 0 the first tie
    logic last_q, last_d;

    assign win1   = bus.req1 & (~bus.req0 | ~last_q);
    assign last_d = (state_q == S_IDLE && any_req) ? win1 : last_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign win1 = bus.req1 & ~bus.req0;
`endif

    assign sel_we    = win1 ? bus.we1    : bus.we0;
    assign sel_addr  = win1 ? bus.addr1  : bus.addr0;
    assign sel_be    = win1 ? bus.be1    : bus.be0;
    assign sel_wdata = win1 ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            port_q     <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            port_q     <= port_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    // A store with no byte enables is granted but never touches memory.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    if (!sel_we) begin
                        state_d = S_RD;
                    end else if (sel_be == '1) begin
                        state_d = S_WR;
                    end else if (sel_be != '0) begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:    state_d = we_q ? S_WR : S_IDLE;
            S_WR:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        port_d     = port_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_wr_d   = (state_d == S_WR);

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    be_d    = sel_be;
                    wdata_d = sel_wdata;
                    port_d  = win1;
                    gnt0_d  = ~win1;
                    gnt1_d  = win1;
                    if (state_d != S_IDLE) begin
                        mem_addr_d = sel_addr;
                    end
                    if (state_d == S_WR) begin
                        mem_din_d = sel_wdata;
                    end
                end
            end
            S_RD: begin
                if (!we_q) begin
                    rdata_d   = bus.mem_dout;
                    rvalid0_d = ~port_q;
                    rvalid1_d = port_q;
                end else begin
                    for (int i = 0; i < BE_W; i++) begin
                        mem_din_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : bus.mem_dout[8*i +: 8];
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.mem_wr   = mem_wr_q;
endmodule
